// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Latency: grant registered one cycle after request; ready/rdata combinational off i_mem_ready.
// Backpressure: i_mem_ready=0 stalls the granted transfer with all o_mem_* held stable.
module mem_port_arbiter #(
    parameter int BW_ADDRESS         = 32,
    parameter int BW_PROCESSOR_BLOCK = 64
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          i_imem_valid,
    output logic                          o_imem_ready,
    input  logic [BW_ADDRESS-1:0]         i_imem_addr,
    output logic [BW_PROCESSOR_BLOCK-1:0] o_imem_rdata,

    input  logic                          i_dmem_valid,
    output logic                          o_dmem_ready,
    input  logic                          i_dmem_wen,
    input  logic [BW_ADDRESS-1:0]         i_dmem_addr,
    input  logic [BW_PROCESSOR_BLOCK-1:0] i_dmem_wdata,
    output logic [BW_PROCESSOR_BLOCK-1:0] o_dmem_rdata,

    output logic                          o_mem_valid,
    input  logic                          i_mem_ready,
    output logic                          o_mem_wen,
    output logic [BW_ADDRESS-1:0]         o_mem_addr,
    output logic [BW_PROCESSOR_BLOCK-1:0] o_mem_wdata,
    input  logic [BW_PROCESSOR_BLOCK-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;
    logic   last_grant_d;
    logic   grant_i;
    logic   grant_d;
    logic   xfer_done;

    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester not granted last time wins.
                if (i_imem_valid && (!i_dmem_valid || last_grant_d)) begin
                    grant_i = 1'b1;
                end else if (i_dmem_valid) begin
                    grant_d = 1'b1;
                end
            end
            SERVE_I: begin
                if (i_mem_ready) begin
                    if (i_dmem_valid) grant_d  = 1'b1;
                    else              state_nx = IDLE;
                end
            end
            SERVE_D: begin
                if (i_mem_ready) begin
                    if (i_imem_valid) grant_i  = 1'b1;
                    else              state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (grant_i) state_nx = SERVE_I;
        if (grant_d) state_nx = SERVE_D;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_mem_valid  <= 1'b0;
            o_mem_wen    <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            last_grant_d <= 1'b1;
        end else begin
            state       <= state_nx;
            o_mem_valid <= (state_nx != IDLE);
            if (grant_i) begin
                o_mem_wen    <= 1'b0;
                o_mem_addr   <= i_imem_addr;
                o_mem_wdata  <= '0;
                last_grant_d <= 1'b0;
            end else if (grant_d) begin
                o_mem_wen    <= i_dmem_wen;
                o_mem_addr   <= i_dmem_addr;
                o_mem_wdata  <= i_dmem_wdata;
                last_grant_d <= 1'b1;
            end
        end
    end

    // A transfer caught by reset is abandoned, so no completion is reported in that cycle.
    assign xfer_done    = o_mem_valid && i_mem_ready && !rst;
    assign o_imem_ready = xfer_done && (state == SERVE_I);
    assign o_dmem_ready = xfer_done && (state == SERVE_D);
    assign o_imem_rdata = o_imem_ready ? i_mem_rdata : '0;
    assign o_dmem_rdata = o_dmem_ready ? i_mem_rdata : '0;

endmodule
